// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified master transmitter with a one-word holding register
module i2s_tx #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    sck_prescaler,
    input  logic          left_justified,
    input  logic [5:0]    sample_size,
    input  logic [1:0]    channels,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          sck,
    output logic          ws,
    output logic          sdo,
    output logic          underrun
);
    logic [7:0]    presc;
    logic [4:0]    bit_ctr;
    logic [DW-1:0] sr;
    logic [DW-1:0] hold;
    logic          hold_valid;
    logic          tick;
    logic          fall;
    logic          load;
    logic          slot_ch;
    logic          slot_en;
    logic [5:0]    size;
    logic [5:0]    lsh;

    // In I2S mode the load lands one SCK after the ws edge, so the slot is the current ws
    always_comb begin
        tick    = en & (presc == 8'd0);
        fall    = tick & sck;
        load    = fall & (bit_ctr == (left_justified ? 5'd0 : 5'd1));
        slot_ch = left_justified ? ~ws : ws;
        slot_en = slot_ch ? channels[0] : channels[1];
        size    = (sample_size == 6'd0 || sample_size > 6'd32) ? 6'd32 : sample_size;
        lsh     = 6'd32 - size;
    end

    assign s_ready = ~hold_valid;
    assign sdo     = sr[DW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            sck        <= 1'b0;
            ws         <= 1'b1;
            bit_ctr    <= '0;
            sr         <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (en)
                presc <= tick ? sck_prescaler : presc - 8'd1;
            if (tick)
                sck <= ~sck;
            if (fall) begin
                bit_ctr <= bit_ctr + 5'd1;
                ws      <= (bit_ctr == 5'd0) ? ~ws : ws;
                sr      <= load ? ((slot_en & hold_valid) ? hold << lsh : '0) : sr << 1;
            end
            underrun <= load & slot_en & ~hold_valid;
            if (s_valid & ~hold_valid) begin
                hold       <= s_data;
                hold_valid <= 1'b1;
            end else if (load & slot_en) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized self-checking bench comparing the serial stream to a slot-level model
module tb_i2s_tx;
    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  sck_prescaler;
    logic        left_justified;
    logic [5:0]  sample_size;
    logic [1:0]  channels;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        sck;
    logic        ws;
    logic        sdo;
    logic        underrun;

    logic [31:0] q[$];
    bit          feed_en;
    bit          fire;
    int          n_chk;
    int          n_fail;

    i2s_tx #(.DW(32)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sck_prescaler(sck_prescaler),
        .left_justified(left_justified),
        .sample_size(sample_size),
        .channels(channels),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .sck(sck),
        .ws(ws),
        .sdo(sdo),
        .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Producer: a word leaves the queue only once the DUT has really taken it
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            fire = s_valid && s_ready && !rst;
            @(posedge clk);
            #1;
            if (fire && q.size() > 0)
                void'(q.pop_front());
            s_valid = feed_en && q.size() > 0;
            if (s_valid)
                s_data = q[0];
        end
    end

    // Slot s carries the s-th enabled word left-aligned, or zeros (and an underrun) if none remain
    task automatic run_test(input bit lj, input logic [5:0] sz, input logic [1:0] ch,
                            input logic [7:0] p, input int nw, input int nslots,
                            input int freeze_at, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] sw[8];
        int          eff, wi, exp_ur, urc, n, cyc, last, budget, s_i, b;
        bit          skip, done, ena;
        logic        psck, pws, pur, exp_sdo, exp_ws;
        logic [2:0]  snap;
        feed_en = 1'b0;
        en      = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({sck, ws, sdo, s_ready, underrun}), 32'b01010);
        left_justified = lj;
        sample_size    = sz;
        channels       = ch;
        sck_prescaler  = p;
        eff = (sz == 6'd0 || sz > 6'd32) ? 32 : int'(sz);
        for (int i = 0; i < nw; i++)
            q.push_back(i == 0 ? w0 : (i == 1 ? w1 : $urandom));
        wi     = 0;
        exp_ur = 0;
        for (int s = 0; s < nslots; s++) begin
            ena = (s % 2 == 1) ? ch[0] : ch[1];
            if (ena && wi < nw) begin
                sw[s] = q[wi] << (32 - eff);
                wi++;
            end else begin
                sw[s] = '0;
                if (ena)
                    exp_ur++;
            end
        end
        rst     = 1'b0;
        feed_en = 1'b1;
        repeat (4) @(negedge clk);
        psck   = sck;
        pws    = ws;
        pur    = underrun;
        en     = 1'b1;
        n      = -1;
        cyc    = 0;
        last   = 0;
        skip   = 1'b1;
        done   = 1'b0;
        urc    = 0;
        budget = nslots * 64 * (int'(p) + 1) + 200;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ws !== pws)
                check("ws_on_sck_fall", 32'({psck, sck}), 32'b10);
            if (underrun) begin
                urc++;
                check("underrun_width", 32'(pur), 32'd0);
                check("underrun_on_fall", 32'({psck, sck}), 32'b10);
            end
            if (sck && !psck) begin
                n++;
                if (n > 0 && !skip)
                    check("sck_period", 32'(cyc - last), 32'(2 * (int'(p) + 1)));
                skip = 1'b0;
                last = cyc;
                s_i  = (n - 1) / 32;
                b    = (n - 1) % 32;
                if (n == 0) begin
                    exp_ws  = 1'b1;
                    exp_sdo = 1'b0;
                end else begin
                    exp_ws  = s_i[0];
                    if (lj)
                        exp_sdo = sw[s_i][31 - b];
                    else if (b != 0)
                        exp_sdo = sw[s_i][32 - b];
                    else
                        exp_sdo = (s_i == 0) ? 1'b0 : sw[s_i - 1][0];
                end
                check("ws", 32'(ws), 32'(exp_ws));
                check("sdo", 32'(sdo), 32'(exp_sdo));
                if (n == 32 * nslots) begin
                    en   = 1'b0;
                    done = 1'b1;
                end else if (freeze_at > 0 && n == freeze_at) begin
                    en   = 1'b0;
                    snap = {sck, ws, sdo};
                    repeat (50) begin
                        @(negedge clk);
                        check("freeze_pins", 32'({sck, ws, sdo}), 32'(snap));
                    end
                    check("freeze_backpressure", 32'(s_ready), 32'd0);
                    en   = 1'b1;
                    skip = 1'b1;
                end
            end
            psck = sck;
            pws  = ws;
            pur  = underrun;
        end
        check("frame_complete", 32'(done), 32'd1);
        check("underrun_count", 32'(urc), 32'(exp_ur));
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        en             = 1'b0;
        feed_en        = 1'b0;
        sck_prescaler  = '0;
        left_justified = 1'b1;
        sample_size    = '0;
        channels       = 2'b11;
        run_test(1'b1, 6'd32, 2'b11, 8'd1, 4, 4, 0, 32'hA5A5_0F0F, 32'h1234_5678);
        q.push_back(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (45) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_midframe", 32'({sck, ws, sdo, s_ready, underrun}), 32'b01010);
        feed_en = 1'b0;
        en      = 1'b0;
        q.delete();
        run_test(1'b0, 6'd16, 2'b11, 8'd2, 4, 4, 0, 32'h0000_BEEF, $urandom);
        run_test(1'b1, 6'd24, 2'b10, 8'd0, 3, 6, 0, $urandom, $urandom);
        run_test(1'b0, 6'd32, 2'b11, 8'd1, 0, 4, 0, 32'd0, 32'd0);
        run_test(1'b1, 6'($urandom_range(1, 32)), 2'b11, 8'd2, 4, 4, 40, $urandom, $urandom);
        repeat (4)
            run_test(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                     8'($urandom_range(0, 4)), $urandom_range(0, 6), 6, 0, $urandom, $urandom);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: generates SCK and WS from the system clock and serialises audio words MSB-first on SDO.
- Supports Philips I2S (one-bit delay) and left-justified framing, and 1..32-bit samples in a 32-bit slot.
- Supports stereo or single-channel operation.
- Fed by a valid/ready stream from the playback FIFO; sits beside the I2S receiver and uses identical SCK/WS timing so both ends share framing.

Parameters:
DW, 32, width of input data word (only 32 supported)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
en  input  1  enable; 0 freezes SCK/WS/bit generation
sck_prescaler  input  8  SCK half-period = sck_prescaler+1 clk cycles
left_justified  input  1  1: left-justified, 0: I2S one-bit delay
sample_size  input  6  valid bits per sample; 0 or >32 treated as 32
channels  input  2  10 left only, 01 right only, 11 stereo, 00 none
s_data  input  32  sample, right-aligned (LSB at bit 0)
s_valid  input  1  s_data valid
s_ready  output  1  block can accept s_data
sck  output  1  serial clock
ws  output  1  word select: 0 left, 1 right
sdo  output  1  serial data, changes on SCK falling edge
underrun  output  1  one-cycle pulse: enabled slot started with no data

Behaviour:
- Reset values: sck=0, ws=1, sdo=0, s_ready=1, underrun=0. Prescaler, bit_ctr, shift register and holding register are all cleared/empty.
- Reset mid-frame aborts the frame immediately; no partial word is retained.
- Prescaler (8b):
  - while en: reloads sck_prescaler when 0, else decrements.
  - tick = en & prescaler==0; sck toggles on tick.
  - SCK period = 2*(sck_prescaler+1) clk; sck_prescaler=0 gives SCK = clk/2.
- Falling event F = tick & sck==1. bit_ctr (5b) increments on F, wraps 31->0, giving 32 SCK per slot and 64 per frame.
- ws toggles on F when bit_ctr==0 (pre-increment value). The first F after reset drives ws to 0, so the left slot comes first.
- Load event L:
  - left_justified=1: F with bit_ctr==0; slot channel = new ws value.
  - left_justified=0: F with bit_ctr==1; slot channel = current ws (MSB one SCK after the ws edge).
  - Slot enabled iff (ws==0 & channels[1]) | (ws==1 & channels[0]).
- Holding register (1 entry):
  - s_ready = ~hold_valid (combinational from the register).
  - transfer on s_valid & s_ready captures s_data; hold_valid<=1.
- On L, if slot enabled and hold_valid:
  - sr <= hold << (32-size), where size is the effective sample_size (left-aligned, zero-filled);
  - hold_valid <= 0.
  - A transfer in the same cycle is impossible because s_ready=0.
- On L, if slot enabled and !hold_valid:
  - sr <= 0; underrun=1 for exactly one clk.
  - A transfer arriving in that same cycle goes to hold and is used at the next enabled slot; there is no bypass.
- On L, if slot disabled: sr <= 0; hold is untouched; no underrun.
- On F without L: sr <= sr<<1 with zero fill.
- sdo = sr[31]:
  - sdo changes in the same clk as sck falls.
  - In I2S mode the last slot bit spills one SCK into the next slot.
  - After the MSB..LSB of a sample, sdo is 0 for the rest of the slot.
- en=0: prescaler, sck, ws, bit_ctr, sr and sdo hold their values. Handshake into hold still operates. Re-asserting en resumes exactly where it stopped.
- Control inputs (left_justified, sample_size, channels, sck_prescaler) are sampled live. Software changes them only with en=0; mid-frame changes give undefined framing for at most one frame but never lock up.

Test Plan:
- Reset: assert rst mid-frame -> sck=0, ws=1, sdo=0, s_ready=1, underrun=0 immediately; first F after release drives ws 1->0.
- LJ stereo: sck_prescaler=1, size=32, channels=11, push 0xA5A50F0F then 0x12345678 -> SCK period 4 clk; ws low for 32 SCK carrying A5A50F0F MSB-first, bit 31 on the ws-falling edge; ws high carrying 12345678.
- I2S 16-bit: left_justified=0, size=16, push 0xBEEF (left) -> MSB appears one SCK after ws falls; bits 1011111011101111 then 15 zeros, then the spill position of the next slot.
- Mono: channels=10, push 3 words -> left slots carry the words in order, right slots all-zero; no underrun while words are supplied ahead of time; s_ready drops after each capture until the next left load.
- Underrun: stereo, supply nothing -> sdo=0 throughout, underrun pulses exactly once per slot (2 pulses/frame), each one clk wide, in the L cycle.
- Freeze/backpressure: deassert en for 50 clk mid-word -> sck/ws/sdo/bit position unchanged; with s_valid held high, only one word is accepted (s_ready=0 afterwards); after en=1 the remaining bits continue with no bit lost or repeated.
